// File: rtl/keyfinder_pkg.sv
// Shared constants and helpers for the wide key comparator: default lane width,
// lane-count helper and the one-hot result-flag encoding.
package keyfinder_pkg;

   localparam int LANE_W_DEF = 48;

   // One-hot result flags; RES_NONE is driven whenever no result is valid.
   typedef enum logic [2:0] {
      RES_NONE = 3'b000,
      RES_LT   = 3'b001,
      RES_GT   = 3'b010,
      RES_EQ   = 3'b100
   } res_e;

   localparam int RES_LT_BIT = 0;
   localparam int RES_GT_BIT = 1;
   localparam int RES_EQ_BIT = 2;

   // Number of lanes needed to cover width bits; the top lane is zero-padded.
   function automatic int nlanes(input int width, input int lane_w);
      return (width + lane_w - 1) / lane_w;
   endfunction

endpackage

// File: rtl/wide_key_comparator_cmp_lane.sv
// One comparison lane: registered equality and unsigned greater-than of two
// LANE_W-bit slices. Kept as a bare compare-and-register so it fits a single
// DSP slice used in pattern-detect / subtract mode.
module cmp_lane #(
   parameter int LANE_W = 48
) (
   input  logic              CLK,
   input  logic [LANE_W-1:0] a,
   input  logic [LANE_W-1:0] b,
   output logic              eq,
   output logic              gt
);

   // Data-path flags only; validity is tracked by the parent, so no reset here.
   always_ff @(posedge CLK) begin
      eq <= (a == b);
      gt <= (a > b);
   end

endmodule

// File: rtl/wide_key_comparator.sv
// Three-stage pipelined masked magnitude comparator for wide keys, with a
// saturating count of equal results.
//   S1: mask operands and zero-pad to whole lanes
//   S2: per-lane eq/gt flags (cmp_lane)
//   S3: MSB-first lane combine into one-hot result
module wide_key_comparator
   import keyfinder_pkg::*;
#(
   parameter int WIDTH   = 128,
   parameter int LANE_W  = LANE_W_DEF,
   parameter int COUNT_W = 32
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               in_valid,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [WIDTH-1:0]   mask,
   input  logic               clr_count,
   output logic               out_valid,
   output logic               equal,
   output logic               a_gt_b,
   output logic               a_lt_b,
   output logic [COUNT_W-1:0] match_count
);

   localparam int NLANES = nlanes(WIDTH, LANE_W);
   localparam int PW     = NLANES * LANE_W;

   logic [PW-1:0]     a_s1;
   logic [PW-1:0]     b_s1;
   logic              v1;
   logic              v2;
   logic              v3;
   logic [NLANES-1:0] eq_s2;
   logic [NLANES-1:0] gt_s2;
   logic              eq_all;
   logic              gt_sel;
   res_e              res_nxt;
   res_e              res_s3;

   // S1 data: masked bits read as 0 in both operands; padding bits are 0 too.
   always_ff @(posedge CLK) begin
      a_s1 <= PW'(a & ~mask);
      b_s1 <= PW'(b & ~mask);
   end

   // Valid pipeline for S1/S2; reset flushes anything in flight.
   always_ff @(posedge CLK) begin
      if (RST) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
      end else begin
         v1 <= in_valid;
         v2 <= v1;
      end
   end

   // S2: one lane comparator per LANE_W slice, lane 0 holding the LSBs.
   for (genvar i = 0; i < NLANES; i++) begin : g_lane
      cmp_lane #(.LANE_W(LANE_W)) u_lane (
         .CLK (CLK),
         .a   (a_s1[i*LANE_W +: LANE_W]),
         .b   (b_s1[i*LANE_W +: LANE_W]),
         .eq  (eq_s2[i]),
         .gt  (gt_s2[i])
      );
   end

   // Lane combine: scanning upward leaves gt_sel holding the highest unequal lane.
   always_comb begin
      eq_all = 1'b1;
      gt_sel = 1'b0;
      for (int i = 0; i < NLANES; i++) begin
         if (!eq_s2[i]) begin
            eq_all = 1'b0;
            gt_sel = gt_s2[i];
         end
      end
      if (!v2)
         res_nxt = RES_NONE;
      else if (eq_all)
         res_nxt = RES_EQ;
      else if (gt_sel)
         res_nxt = RES_GT;
      else
         res_nxt = RES_LT;
   end

   // S3: registered result; flags are all-zero whenever the result is not valid.
   always_ff @(posedge CLK) begin
      if (RST) begin
         v3     <= 1'b0;
         res_s3 <= RES_NONE;
      end else begin
         v3     <= v2;
         res_s3 <= res_nxt;
      end
   end

   assign out_valid = v3;
   assign equal     = res_s3[RES_EQ_BIT];
   assign a_gt_b    = res_s3[RES_GT_BIT];
   assign a_lt_b    = res_s3[RES_LT_BIT];

   // Saturating match counter; clear beats a same-cycle increment.
   always_ff @(posedge CLK) begin
      if (RST || clr_count)
         match_count <= '0;
      else if (v3 && (res_s3 == RES_EQ) && (match_count != {COUNT_W{1'b1}}))
         match_count <= match_count + COUNT_W'(1);
   end

endmodule

// File: tb/tb_wide_key_comparator.sv
// Directed bench for wide_key_comparator: vector table for single results plus
// hand-written sequences for latency, throughput, reset flush and counter limits.
module tb_wide_key_comparator;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic [127:0] a;
   logic [127:0] b;
   logic [127:0] mask;
   logic         clr_count;

   logic         ov0, eq0, gt0, lt0;
   logic [31:0]  cnt0;
   logic         ov3, eq3, gt3, lt3;
   logic [2:0]   cnt3;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   wide_key_comparator #(.WIDTH(128), .LANE_W(48), .COUNT_W(32)) dut (
      .CLK(clk), .RST(rst), .in_valid(in_valid), .a(a), .b(b), .mask(mask),
      .clr_count(clr_count), .out_valid(ov0), .equal(eq0), .a_gt_b(gt0),
      .a_lt_b(lt0), .match_count(cnt0)
   );

   wide_key_comparator #(.WIDTH(128), .LANE_W(48), .COUNT_W(3)) dut_c3 (
      .CLK(clk), .RST(rst), .in_valid(in_valid), .a(a), .b(b), .mask(mask),
      .clr_count(clr_count), .out_valid(ov3), .equal(eq3), .a_gt_b(gt3),
      .a_lt_b(lt3), .match_count(cnt3)
   );

   typedef struct {
      logic [127:0] a;
      logic [127:0] b;
      logic [127:0] mask;
      logic         e_eq;
      logic         e_gt;
      logic         e_lt;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_res(input string tag, input logic ev, input logic ee,
                          input logic eg, input logic el);
      chk({tag, ".out_valid"}, 128'(ov0), 128'(ev));
      chk({tag, ".equal"},     128'(eq0), 128'(ee));
      chk({tag, ".a_gt_b"},    128'(gt0), 128'(eg));
      chk({tag, ".a_lt_b"},    128'(lt0), 128'(el));
      chk({tag, ".c3_equal"},  128'(eq3), 128'(ee));
   endtask

   task automatic drive(input logic v, input logic [127:0] va, input logic [127:0] vb,
                        input logic [127:0] vm);
      in_valid = v;
      a        = va;
      b        = vb;
      mask     = vm;
   endtask

   initial begin
      logic [127:0] k;
      logic [127:0] top1;
      logic [127:0] low_ones;
      int           n_eq;
      int           exp_c;

      k        = 128'h00112233_44556677_8899AABB_CCDDEEFF;
      top1     = 128'h1 << 127;
      low_ones = {1'b0, {127{1'b1}}};

      vecs[0] = '{a: k,                b: k,                mask: '0,            e_eq: 1, e_gt: 0, e_lt: 0};
      vecs[1] = '{a: top1,             b: low_ones,         mask: '0,            e_eq: 0, e_gt: 1, e_lt: 0};
      vecs[2] = '{a: low_ones,         b: top1,             mask: '0,            e_eq: 0, e_gt: 0, e_lt: 1};
      vecs[3] = '{a: 128'h5,           b: 128'h4,           mask: 128'h1,        e_eq: 1, e_gt: 0, e_lt: 0};
      vecs[4] = '{a: 128'h5,           b: 128'h4,           mask: '0,            e_eq: 0, e_gt: 1, e_lt: 0};
      vecs[5] = '{a: 128'hDEADBEEF,    b: 128'h1234,        mask: '1,            e_eq: 1, e_gt: 0, e_lt: 0};
      vecs[6] = '{a: 128'h0,           b: 128'h1,           mask: '0,            e_eq: 0, e_gt: 0, e_lt: 1};
      vecs[7] = '{a: 128'h1 << 48,     b: 128'hFFFF_FFFF_FFFF, mask: '0,         e_eq: 0, e_gt: 1, e_lt: 0};
      vecs[8] = '{a: top1 | 128'h1,    b: 128'h2,           mask: top1,          e_eq: 0, e_gt: 0, e_lt: 1};

      // Reset state
      rst = 1'b1;
      clr_count = 1'b0;
      drive(1'b0, '0, '0, '0);
      tick();
      tick();
      chk_res("reset", 0, 0, 0, 0);
      chk("reset.count", 128'(cnt0), 128'd0);
      chk("reset.count_c3", 128'(cnt3), 128'd0);
      rst = 1'b0;
      tick();

      // Single sample: exact latency of 3, count visible one cycle later
      drive(1'b1, k, k, '0);
      tick();
      drive(1'b0, '0, '0, '0);
      chk("lat.n1_valid", 128'(ov0), 128'd0);
      tick();
      chk("lat.n2_valid", 128'(ov0), 128'd0);
      tick();
      chk_res("lat.n3", 1, 1, 0, 0);
      chk("lat.n3_count", 128'(cnt0), 128'd0);
      tick();
      chk("lat.n4_count", 128'(cnt0), 128'd1);
      chk_res("lat.n4_idle", 0, 0, 0, 0);

      // Vector table, one isolated sample each
      n_eq = 1;
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].mask);
         tick();
         drive(1'b0, '0, '0, '0);
         tick();
         tick();
         chk_res($sformatf("vec%0d", i), 1, vecs[i].e_eq, vecs[i].e_gt, vecs[i].e_lt);
         if (vecs[i].e_eq) n_eq++;
         tick();
      end
      chk("vec.count", 128'(cnt0), 128'(n_eq));

      // Ten back-to-back samples: eq, gt, eq, lt, ... in order
      clr_count = 1'b1;
      tick();
      clr_count = 1'b0;
      for (int c = 0; c < 13; c++) begin
         if (c >= 3) begin
            int j;
            j = c - 3;
            chk_res($sformatf("b2b%0d", j), 1, (j % 2 == 0), (j % 4 == 1), (j % 4 == 3));
         end
         if (c < 10) begin
            logic [127:0] p;
            p = (128'(c) << 100) | (128'(c) << 40) | 128'(c + 16);
            if (c % 2 == 0)      drive(1'b1, p, p, '0);
            else if (c % 4 == 1) drive(1'b1, p + 128'h1, p, '0);
            else                 drive(1'b1, p, p + 128'h1, '0);
         end else begin
            drive(1'b0, '0, '0, '0);
         end
         tick();
      end
      chk("b2b.tail_valid", 128'(ov0), 128'd0);
      chk("b2b.count", 128'(cnt0), 128'd5);

      // Reset one cycle after two samples; a sample offered during reset is ignored
      drive(1'b1, k, k, '0);
      tick();
      drive(1'b1, k, k, '0);
      tick();
      rst = 1'b1;
      drive(1'b1, k, k, '0);
      tick();
      rst = 1'b0;
      drive(1'b0, '0, '0, '0);
      for (int c = 0; c < 5; c++) begin
         chk_res($sformatf("rstflush%0d", c), 0, 0, 0, 0);
         chk($sformatf("rstflush%0d.count", c), 128'(cnt0), 128'd0);
         tick();
      end
      drive(1'b1, 128'h10, 128'h11, '0);
      tick();
      drive(1'b0, '0, '0, '0);
      tick();
      chk("post_rst.n2_valid", 128'(ov0), 128'd0);
      tick();
      chk_res("post_rst.n3", 1, 0, 0, 1);
      tick();

      // Nine equal samples: 3-bit counter saturates at 7, wide one reaches 9
      clr_count = 1'b1;
      tick();
      clr_count = 1'b0;
      for (int c = 0; c < 13; c++) begin
         if (c >= 4) begin
            exp_c = (c - 3 > 9) ? 9 : c - 3;
            chk($sformatf("sat%0d.count", c), 128'(cnt0), 128'(exp_c));
            chk($sformatf("sat%0d.count_c3", c), 128'(cnt3), 128'((exp_c > 7) ? 7 : exp_c));
         end
         if (c < 9) drive(1'b1, 128'(c) << 64, 128'(c) << 64, '0);
         else       drive(1'b0, '0, '0, '0);
         tick();
      end

      // Clear in the same cycle as an increment
      drive(1'b1, k, k, '0);
      tick();
      drive(1'b0, '0, '0, '0);
      tick();
      tick();
      chk("clr_inc.valid", 128'(ov0), 128'd1);
      clr_count = 1'b1;
      tick();
      clr_count = 1'b0;
      chk("clr_inc.count", 128'(cnt0), 128'd0);
      chk("clr_inc.count_c3", 128'(cnt3), 128'd0);
      tick();
      chk("clr_inc.stays", 128'(cnt3), 128'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wide_key_comparator.md
WIDE_KEY_COMPARATOR -- requirements
Module: wide_key_comparator

Interface
REQ-001 SHALL have parameter WIDTH, default 128: compared operand width in bits, 1..384.
REQ-002 SHALL have parameter LANE_W, default 48: per-lane slice width.
REQ-003 SHALL have parameter COUNT_W, default 32: match counter width.
REQ-004 SHALL have port CLK  input  1: single clock; all logic on its rising edge.
REQ-005 SHALL have port RST  input  1: reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1: a, b and mask are valid this cycle.
REQ-007 SHALL have port a  input  WIDTH: operand A, unsigned.
REQ-008 SHALL have port b  input  WIDTH: operand B, unsigned.
REQ-009 SHALL have port mask  input  WIDTH: 1 = ignore bit; the bit is treated as 0 in both operands.
REQ-010 SHALL have port clr_count  input  1: synchronous clear of match_count.
REQ-011 SHALL have port out_valid  output  1: result outputs valid this cycle.
REQ-012 SHALL have port equal  output  1: masked A == masked B.
REQ-013 SHALL have port a_gt_b  output  1: masked A > masked B, unsigned.
REQ-014 SHALL have port a_lt_b  output  1: masked A < masked B, unsigned.
REQ-015 SHALL have port match_count  output  COUNT_W: number of results with equal=1.

Function
REQ-016 SHALL split operands into NLANES = ceil(WIDTH/LANE_W) lanes, lane 0 = LSBs, and zero-pad the top lane.
REQ-017 SHALL use a 3-stage pipeline: S1 registers a&~mask, b&~mask and in_valid; S2 registers per-lane eq and gt flags; S3 registers the combined result.
REQ-018 SHALL have a fixed latency of 3: a sample accepted at cycle N yields out_valid=1 at cycle N+3.
REQ-019 SHALL accept one sample per cycle with no back-pressure; back-to-back samples produce back-to-back results in order.
REQ-020 SHALL combine lanes MSB-first in S3: equal = AND of all lane eq; a_gt_b = gt of the highest non-equal lane; a_lt_b = NOT equal AND NOT a_gt_b.
REQ-021 SHALL assert exactly one of equal, a_gt_b, a_lt_b whenever out_valid=1.
REQ-022 SHALL hold equal, a_gt_b and a_lt_b at 0 when out_valid=0.
REQ-023 SHALL yield equal=1 when mask is all ones, regardless of a and b.
REQ-024 SHALL increment match_count by 1 in the cycle after a cycle with out_valid=1 and equal=1.
REQ-025 SHALL saturate match_count at 2^COUNT_W-1; it SHALL NOT wrap.
REQ-026 SHALL make match_count 0 on the next edge when clr_count=1; clear SHALL win over a simultaneous increment.

Reset
REQ-027 SHALL, while RST=1, clear all pipeline valid bits, out_valid, equal, a_gt_b, a_lt_b and match_count to 0 on the next edge.
REQ-028 SHALL discard samples in flight at reset: no out_valid for samples accepted at or before the reset cycle.
REQ-029 SHALL ignore in_valid during RST=1; the first sample accepted after RST deasserts yields a result 3 cycles later.
REQ-030 SHALL NOT require reset of data-path registers (only valid and counter state).

Structure
REQ-031 SHALL place LANE_W default, NLANES computation function and the result-flag encoding in shared package keyfinder_pkg.
REQ-032 SHALL implement a single sub-module cmp_lane (one lane: registered eq and gt), instantiated NLANES times via generate; cmp_lane SHALL be mappable onto one DSP48E2 in pattern-detect/subtract mode.

Verification
REQ-033 SHALL test: WIDTH=128, a=b=128'h00112233_44556677_8899AABB_CCDDEEFF, mask=0, in_valid one cycle at N -> out_valid at N+3, equal=1, match_count=1 at N+4.
REQ-034 SHALL test: a=128'h1<<127, b=128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF>>1 -> a_gt_b=1; with a and b swapped -> a_lt_b=1 (top-lane decision overrides lower lanes).
REQ-035 SHALL test: a=128'h5, b=128'h4, mask=128'h1 -> equal=1; with mask=0 -> a_gt_b=1.
REQ-036 SHALL test: 10 back-to-back samples, alternating equal/unequal -> 10 consecutive out_valid cycles in order, match_count=5.
REQ-037 SHALL test: RST=1 one cycle after 2 samples are accepted -> no out_valid for either sample, all outputs 0.
REQ-038 SHALL test: COUNT_W=3 with 9 equal samples -> match_count saturates at 7; clr_count in the same cycle as an increment -> match_count=0.
